trap_sequencer: RTL and testbench

Multi-cycle trap-entry controller placed between the commit stage and the CSR file / fetch redirect. It arbitrates the exceptions flagged on the committing instruction against pending machine interrupts and picks one trap by fixed priority. It then sequences the CSR updates (mepc/mcause/mtval, then mstatus) and the pipeline flush over successive cycles. While it is busy it holds the commit slot.

---
 rtl/trap_sequencer_if.sv | 84 ++++++++
 rtl/trap_sequencer.sv | 164 ++++++++++++++++
 tb/tb_trap_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_sequencer_if.sv
// trap_sequencer_if
//   Bundles every signal between the trap sequencer and its neighbours
//   (commit stage, CSR file, IFU redirect). clk/rst are not part of it.
//
//   modport slave  : the trap sequencer itself (consumes commit/CSR inputs,
//                    produces the CSR write strobes and the redirect).
//   modport master : the surrounding core / testbench.
//
//   Handshake: flush_req is a level raised in FLUSH together with a stable
//   flush_pc. The redirect is transferred on the first rising edge where
//   flush_req and flush_ack are both 1. flush_ack seen while flush_req is 0
//   has no effect. The cmt_*_ena strobes carry no back-pressure: each is a
//   one-cycle write pulse that the CSR file must accept.
interface trap_sequencer_if #(
  parameter int PC_W = 32
);
  // commit slot
  logic            evt_valid;
  logic [PC_W-1:0] evt_pc;
  logic [PC_W-1:0] evt_badaddr;
  // exception flags of the committing instruction
  logic            ex_ifu_buserr;
  logic            ex_ilegl;
  logic            ex_ifu_misalgn;
  logic            ex_ecall;
  logic            ex_ebreak;
  logic            ex_misalgn;
  logic            ex_buserr;
  logic            ex_is_st;
  // interrupt pending / enable
  logic            ext_irq_r;
  logic            sft_irq_r;
  logic            tmr_irq_r;
  logic            meie_r;
  logic            msie_r;
  logic            mtie_r;
  logic            status_mie_r;
  logic            dbg_mode;
  logic [PC_W-1:0] csr_mtvec_r;
  // redirect handshake
  logic            flush_ack;
  logic            flush_req;
  logic [PC_W-1:0] flush_pc;
  // trap control / CSR writes
  logic            trap_take;
  logic            trap_busy;
  logic [PC_W-1:0] cmt_epc;
  logic            cmt_epc_ena;
  logic [31:0]     cmt_cause;
  logic            cmt_cause_ena;
  logic [PC_W-1:0] cmt_badaddr;
  logic            cmt_badaddr_ena;
  logic            cmt_status_ena;
  // FSM state for debug/observation
  logic [1:0]      dbg_state;

  modport slave (
    input  evt_valid, evt_pc, evt_badaddr,
    input  ex_ifu_buserr, ex_ilegl, ex_ifu_misalgn, ex_ecall, ex_ebreak,
    input  ex_misalgn, ex_buserr, ex_is_st,
    input  ext_irq_r, sft_irq_r, tmr_irq_r,
    input  meie_r, msie_r, mtie_r, status_mie_r, dbg_mode, csr_mtvec_r,
    input  flush_ack,
    output flush_req, flush_pc,
    output trap_take, trap_busy,
    output cmt_epc, cmt_epc_ena, cmt_cause, cmt_cause_ena,
    output cmt_badaddr, cmt_badaddr_ena, cmt_status_ena,
    output dbg_state
  );

  modport master (
    output evt_valid, evt_pc, evt_badaddr,
    output ex_ifu_buserr, ex_ilegl, ex_ifu_misalgn, ex_ecall, ex_ebreak,
    output ex_misalgn, ex_buserr, ex_is_st,
    output ext_irq_r, sft_irq_r, tmr_irq_r,
    output meie_r, msie_r, mtie_r, status_mie_r, dbg_mode, csr_mtvec_r,
    output flush_ack,
    input  flush_req, flush_pc,
    input  trap_take, trap_busy,
    input  cmt_epc, cmt_epc_ena, cmt_cause, cmt_cause_ena,
    input  cmt_badaddr, cmt_badaddr_ena, cmt_status_ena,
    input  dbg_state
  );
endinterface

// File: rtl/trap_sequencer.sv
// trap_sequencer
//   Trap-entry controller between commit and the CSR file / fetch redirect.
//   Selects one trap (exceptions first, then enabled interrupts) for the
//   committing instruction, captures epc/cause/badaddr/target, then walks
//   WR_CSR -> WR_STATUS -> FLUSH, holding the commit slot while busy.
//
//   Ports
//     clk : core clock, rising edge
//     rst : asynchronous active-high reset
//     bus : trap_sequencer_if.slave (commit inputs, CSR strobes, redirect)
module trap_sequencer #(
  parameter int PC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  trap_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WR_CSR    = 2'd1,
    WR_STATUS = 2'd2,
    FLUSH     = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // captured trap context, stable for the whole sequence
  logic [PC_W-1:0] epc_q;
  logic [31:0]     cause_q;
  logic [PC_W-1:0] badaddr_q;
  logic [PC_W-1:0] target_q;

  // ---------------------------------------------------------------------
  // trap selection
  // ---------------------------------------------------------------------
  logic            irq_en;
  logic [2:0]      pend;        // {ext, sft, tmr}
  logic            any_ex;
  logic            any_irq;
  logic            take;
  logic            sel_irq;
  logic [4:0]      sel_code;
  logic [PC_W-1:0] sel_badaddr;
  logic [31:0]     sel_cause;
  logic [PC_W-1:0] vec_base;
  logic [PC_W-1:0] sel_target;

  assign irq_en  = bus.status_mie_r & ~bus.dbg_mode;
  assign pend    = {bus.ext_irq_r & bus.meie_r,
                    bus.sft_irq_r & bus.msie_r,
                    bus.tmr_irq_r & bus.mtie_r};
  assign any_ex  = bus.ex_ifu_buserr | bus.ex_ilegl | bus.ex_ifu_misalgn |
                   bus.ex_ecall | bus.ex_ebreak | bus.ex_misalgn |
                   bus.ex_buserr;
  assign any_irq = irq_en & (|pend);

  // rst gating keeps trap_take low while reset is held even though the
  // state register already reads IDLE during reset.
  assign take = ~rst & (state == IDLE) & bus.evt_valid & (any_ex | any_irq);

  // Fixed priority: exceptions (in architectural order) before interrupts.
  always_comb begin
    sel_irq     = 1'b0;
    sel_code    = 5'd0;
    sel_badaddr = '0;
    if (bus.ex_ifu_buserr) begin
      sel_code    = 5'd1;
      sel_badaddr = bus.evt_pc;
    end else if (bus.ex_ilegl) begin
      sel_code    = 5'd2;
    end else if (bus.ex_ifu_misalgn) begin
      sel_code    = 5'd0;
      sel_badaddr = bus.evt_pc;
    end else if (bus.ex_ecall) begin
      sel_code    = 5'd11;
    end else if (bus.ex_ebreak) begin
      sel_code    = 5'd3;
    end else if (bus.ex_misalgn) begin
      sel_code    = bus.ex_is_st ? 5'd6 : 5'd4;
      sel_badaddr = bus.evt_badaddr;
    end else if (bus.ex_buserr) begin
      sel_code    = bus.ex_is_st ? 5'd7 : 5'd5;
      sel_badaddr = bus.evt_badaddr;
    end else begin
      // only reached with take=1 when an enabled interrupt is pending
      sel_irq = 1'b1;
      if (pend[2]) begin
        sel_code = 5'd11;
      end else if (pend[1]) begin
        sel_code = 5'd3;
      end else begin
        sel_code = 5'd7;
      end
    end
  end

  assign sel_cause = {sel_irq, 26'd0, sel_code};
  assign vec_base  = {bus.csr_mtvec_r[PC_W-1:2], 2'b00};

  // Vectored mode applies to interrupts only; exceptions go to the base.
  always_comb begin
    sel_target = vec_base;
    if (sel_irq && (bus.csr_mtvec_r[1:0] == 2'b01)) begin
      sel_target = vec_base + (PC_W'(sel_code) << 2);
    end
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (take) state_nxt = WR_CSR;
      WR_CSR:    state_nxt = WR_STATUS;
      WR_STATUS: state_nxt = FLUSH;
      FLUSH:     if (bus.flush_ack) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Context is loaded only on an accepted trap, so later input activity
  // cannot disturb an in-flight sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      epc_q     <= '0;
      cause_q   <= '0;
      badaddr_q <= '0;
      target_q  <= '0;
    end else if (take) begin
      epc_q     <= bus.evt_pc;
      cause_q   <= sel_cause;
      badaddr_q <= sel_badaddr;
      target_q  <= sel_target;
    end
  end

  // ---------------------------------------------------------------------
  // outputs (decoded from the state register; async reset clears them)
  // ---------------------------------------------------------------------
  assign bus.trap_take       = take;
  assign bus.trap_busy       = (state != IDLE);
  assign bus.cmt_epc_ena     = (state == WR_CSR);
  assign bus.cmt_cause_ena   = (state == WR_CSR);
  assign bus.cmt_badaddr_ena = (state == WR_CSR);
  assign bus.cmt_status_ena  = (state == WR_STATUS);
  assign bus.flush_req       = (state == FLUSH);
  assign bus.cmt_epc         = epc_q;
  assign bus.cmt_cause       = cause_q;
  assign bus.cmt_badaddr     = badaddr_q;
  assign bus.flush_pc        = target_q;
  assign bus.dbg_state       = state;

endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer
//   Directed scenarios followed by randomized traps, each checked against a
//   priority-list reference model of trap selection and sequencing.
module tb_trap_sequencer;
  localparam int PC_W = 32;

  typedef struct packed {
    logic            evt_valid;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] badaddr;
    logic            ifu_buserr, ilegl, ifu_misalgn, ecall, ebreak, misalgn, buserr;
    logic            is_st;
    logic            ext, sft, tmr;
    logic            meie, msie, mtie, mie, dbg;
    logic [PC_W-1:0] mtvec;
  } stim_t;

  typedef struct packed {
    logic            take;
    logic [PC_W-1:0] epc;
    logic [31:0]     cause;
    logic [PC_W-1:0] bad;
    logic [PC_W-1:0] target;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  trap_sequencer_if #(.PC_W(PC_W)) bus ();

  trap_sequencer #(.PC_W(PC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic exp_t model(input stim_t s);
    exp_t e;
    logic ex[7];
    int   ec[7];
    logic ir[3];
    int   ic[3];
    int   code;
    bit   irq;
    e    = '0;
    code = -1;
    irq  = 0;
    ex = '{s.ifu_buserr, s.ilegl, s.ifu_misalgn, s.ecall, s.ebreak, s.misalgn, s.buserr};
    ec = '{1, 2, 0, 11, 3, s.is_st ? 6 : 4, s.is_st ? 7 : 5};
    ir = '{s.ext & s.meie, s.sft & s.msie, s.tmr & s.mtie};
    ic = '{11, 3, 7};
    for (int i = 0; i < 7; i++) begin
      if (ex[i] && code < 0) begin
        code = ec[i];
        if (i == 0 || i == 2) e.bad = s.pc;
        else if (i >= 5)      e.bad = s.badaddr;
      end
    end
    if (code < 0 && s.mie && !s.dbg) begin
      for (int j = 0; j < 3; j++) begin
        if (ir[j] && code < 0) begin
          code = ic[j];
          irq  = 1;
        end
      end
    end
    e.take   = s.evt_valid && (code >= 0);
    e.epc    = s.pc;
    e.cause  = (irq ? 32'h8000_0000 : 32'h0) | 32'(code);
    e.target = (s.mtvec & ~PC_W'(3)) +
               ((irq && s.mtvec[1:0] == 2'b01) ? PC_W'(4 * code) : PC_W'(0));
    return e;
  endfunction

  function automatic exp_t mk_exp(input logic [31:0] cause, input logic [PC_W-1:0] bad,
                                  input logic [PC_W-1:0] target, input logic [PC_W-1:0] epc);
    exp_t e;
    e.take   = 1'b1;
    e.epc    = epc;
    e.cause  = cause;
    e.bad    = bad;
    e.target = target;
    return e;
  endfunction

  // ---------------- drivers ----------------
  task automatic apply(input stim_t s);
    bus.evt_valid      = s.evt_valid;
    bus.evt_pc         = s.pc;
    bus.evt_badaddr    = s.badaddr;
    bus.ex_ifu_buserr  = s.ifu_buserr;
    bus.ex_ilegl       = s.ilegl;
    bus.ex_ifu_misalgn = s.ifu_misalgn;
    bus.ex_ecall       = s.ecall;
    bus.ex_ebreak      = s.ebreak;
    bus.ex_misalgn     = s.misalgn;
    bus.ex_buserr      = s.buserr;
    bus.ex_is_st       = s.is_st;
    bus.ext_irq_r      = s.ext;
    bus.sft_irq_r      = s.sft;
    bus.tmr_irq_r      = s.tmr;
    bus.meie_r         = s.meie;
    bus.msie_r         = s.msie;
    bus.mtie_r         = s.mtie;
    bus.status_mie_r   = s.mie;
    bus.dbg_mode       = s.dbg;
    bus.csr_mtvec_r    = s.mtvec;
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s.evt_valid   = ($urandom_range(0, 3) != 0);
    s.pc          = $urandom;
    s.badaddr     = $urandom;
    s.ifu_buserr  = ($urandom_range(0, 7) == 0);
    s.ilegl       = ($urandom_range(0, 7) == 0);
    s.ifu_misalgn = ($urandom_range(0, 7) == 0);
    s.ecall       = ($urandom_range(0, 7) == 0);
    s.ebreak      = ($urandom_range(0, 7) == 0);
    s.misalgn     = ($urandom_range(0, 7) == 0);
    s.buserr      = ($urandom_range(0, 7) == 0);
    s.is_st       = 1'($urandom_range(0, 1));
    s.ext         = 1'($urandom_range(0, 1));
    s.sft         = 1'($urandom_range(0, 1));
    s.tmr         = 1'($urandom_range(0, 1));
    s.meie        = 1'($urandom_range(0, 1));
    s.msie        = 1'($urandom_range(0, 1));
    s.mtie        = 1'($urandom_range(0, 1));
    s.mie         = ($urandom_range(0, 3) != 0);
    s.dbg         = ($urandom_range(0, 3) == 0);
    s.mtvec       = $urandom;
    return s;
  endfunction

  // in-sequence noise: always a valid ecall, other fields random
  function automatic stim_t junk_stim();
    stim_t s;
    s           = rand_stim();
    s.evt_valid = 1'b1;
    s.ecall     = 1'b1;
    return s;
  endfunction

  function automatic stim_t idle_stim();
    stim_t s;
    s = '0;
    return s;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, ".trap_take"},   64'(bus.trap_take), 64'd0);
    check({tag, ".trap_busy"},   64'(bus.trap_busy), 64'd0);
    check({tag, ".epc_ena"},     64'(bus.cmt_epc_ena), 64'd0);
    check({tag, ".cause_ena"},   64'(bus.cmt_cause_ena), 64'd0);
    check({tag, ".badaddr_ena"}, 64'(bus.cmt_badaddr_ena), 64'd0);
    check({tag, ".status_ena"},  64'(bus.cmt_status_ena), 64'd0);
    check({tag, ".flush_req"},   64'(bus.flush_req), 64'd0);
    check({tag, ".epc"},         64'(bus.cmt_epc), 64'd0);
    check({tag, ".cause"},       64'(bus.cmt_cause), 64'd0);
    check({tag, ".badaddr"},     64'(bus.cmt_badaddr), 64'd0);
    check({tag, ".flush_pc"},    64'(bus.flush_pc), 64'd0);
  endtask

  // Called just after a rising edge with the DUT idle. Applies s in cycle T
  // and walks the whole trap sequence, acking after ack_delay FLUSH cycles.
  task automatic run_trap(input string tag, input stim_t s, input exp_t e, input int ack_delay);
    apply(s);
    bus.flush_ack = 1'b0;
    #1;
    check({tag, ".take"}, 64'(bus.trap_take), 64'(e.take));
    check({tag, ".idle_busy"}, 64'(bus.trap_busy), 64'd0);
    @(posedge clk); #1;
    if (!e.take) begin
      apply(idle_stim());
      check({tag, ".no_trap_busy"}, 64'(bus.trap_busy), 64'd0);
      return;
    end
    // T+1: WR_CSR; stray ack and new valid events must be ignored
    apply(junk_stim());
    bus.flush_ack = 1'($urandom_range(0, 1));
    #1;
    check({tag, ".csr.busy"},        64'(bus.trap_busy), 64'd1);
    check({tag, ".csr.take"},        64'(bus.trap_take), 64'd0);
    check({tag, ".csr.epc_ena"},     64'(bus.cmt_epc_ena), 64'd1);
    check({tag, ".csr.cause_ena"},   64'(bus.cmt_cause_ena), 64'd1);
    check({tag, ".csr.badaddr_ena"}, 64'(bus.cmt_badaddr_ena), 64'd1);
    check({tag, ".csr.status_ena"},  64'(bus.cmt_status_ena), 64'd0);
    check({tag, ".csr.flush_req"},   64'(bus.flush_req), 64'd0);
    check({tag, ".csr.epc"},         64'(bus.cmt_epc), 64'(e.epc));
    check({tag, ".csr.cause"},       64'(bus.cmt_cause), 64'(e.cause));
    check({tag, ".csr.badaddr"},     64'(bus.cmt_badaddr), 64'(e.bad));
    // T+2: WR_STATUS
    @(posedge clk); #1;
    apply(junk_stim());
    bus.flush_ack = 1'($urandom_range(0, 1));
    #1;
    check({tag, ".st.status_ena"}, 64'(bus.cmt_status_ena), 64'd1);
    check({tag, ".st.epc_ena"},    64'(bus.cmt_epc_ena), 64'd0);
    check({tag, ".st.flush_req"},  64'(bus.flush_req), 64'd0);
    check({tag, ".st.busy"},       64'(bus.trap_busy), 64'd1);
    check({tag, ".st.take"},       64'(bus.trap_take), 64'd0);
    // T+3 onward: FLUSH, held until ack
    @(posedge clk); #1;
    bus.flush_ack = 1'b0;
    for (int i = 0; i < ack_delay; i++) begin
      apply(junk_stim());
      #1;
      check({tag, ".fl.req"},        64'(bus.flush_req), 64'd1);
      check({tag, ".fl.pc"},         64'(bus.flush_pc), 64'(e.target));
      check({tag, ".fl.busy"},       64'(bus.trap_busy), 64'd1);
      check({tag, ".fl.take"},       64'(bus.trap_take), 64'd0);
      check({tag, ".fl.status_ena"}, 64'(bus.cmt_status_ena), 64'd0);
      @(posedge clk); #1;
    end
    apply(junk_stim());
    bus.flush_ack = 1'b1;
    #1;
    check({tag, ".ack.req"}, 64'(bus.flush_req), 64'd1);
    check({tag, ".ack.pc"},  64'(bus.flush_pc), 64'(e.target));
    @(posedge clk); #1;
    bus.flush_ack = 1'b0;
    apply(idle_stim());
    check({tag, ".done.busy"}, 64'(bus.trap_busy), 64'd0);
    check({tag, ".done.req"},  64'(bus.flush_req), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    stim_t s;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    apply(idle_stim());
    bus.flush_ack = 1'b0;
    #2;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // illegal instruction, direct mode
    s = idle_stim();
    s.evt_valid = 1; s.ilegl = 1; s.pc = 32'h80; s.mtvec = 32'h100;
    run_trap("ilegl", s, mk_exp(32'd2, 32'h0, 32'h100, 32'h80), 0);

    // vectored external interrupt beating timer
    s = idle_stim();
    s.evt_valid = 1; s.pc = 32'h400; s.mtvec = 32'h201;
    s.ext = 1; s.tmr = 1; s.meie = 1; s.mtie = 1; s.mie = 1;
    run_trap("vec_irq", s, mk_exp(32'h8000_000B, 32'h0, 32'h22C, 32'h400), 2);

    // store misalign beats pending timer; base target despite vectored mtvec
    s = idle_stim();
    s.evt_valid = 1; s.pc = 32'h500; s.badaddr = 32'h1003; s.misalgn = 1; s.is_st = 1;
    s.tmr = 1; s.mtie = 1; s.mie = 1; s.mtvec = 32'h201;
    run_trap("ex_vs_irq", s, mk_exp(32'd6, 32'h1003, 32'h200, 32'h500), 1);

    // masking: MIE=0, then dbg_mode=1
    s = idle_stim();
    s.evt_valid = 1; s.ext = 1; s.sft = 1; s.tmr = 1;
    s.meie = 1; s.msie = 1; s.mtie = 1; s.mie = 0; s.mtvec = 32'h100;
    apply(s);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("mask_mie.take", 64'(bus.trap_take), 64'd0);
      check("mask_mie.busy", 64'(bus.trap_busy), 64'd0);
      @(posedge clk); #1;
    end
    s.mie = 1; s.dbg = 1;
    apply(s);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("mask_dbg.take", 64'(bus.trap_take), 64'd0);
      check("mask_dbg.busy", 64'(bus.trap_busy), 64'd0);
      @(posedge clk); #1;
    end

    // long flush stall with ecalls arriving, then back-to-back ecall
    s = idle_stim();
    s.evt_valid = 1; s.ebreak = 1; s.pc = 32'h600; s.mtvec = 32'h300;
    run_trap("stall", s, mk_exp(32'd3, 32'h0, 32'h300, 32'h600), 5);
    s = idle_stim();
    s.evt_valid = 1; s.ecall = 1; s.pc = 32'h604; s.mtvec = 32'h301;
    run_trap("ecall", s, mk_exp(32'd11, 32'h0, 32'h300, 32'h604), 0);

    // reset asserted during WR_STATUS
    s = idle_stim();
    s.evt_valid = 1; s.ifu_buserr = 1; s.pc = 32'h700; s.mtvec = 32'h900;
    apply(s);
    #1;
    check("rst_mid.take", 64'(bus.trap_take), 64'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_mid.status_ena", 64'(bus.cmt_status_ena), 64'd1);
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid");
    @(posedge clk); #1;
    rst = 1'b0;
    apply(idle_stim());
    for (int i = 0; i < 4; i++) begin
      #1;
      check("post_rst.req",  64'(bus.flush_req), 64'd0);
      check("post_rst.busy", 64'(bus.trap_busy), 64'd0);
      @(posedge clk); #1;
    end

    // randomized traps against the model
    for (int n = 0; n < 300; n++) begin
      s = rand_stim();
      run_trap("rand", s, model(s), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
